// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan path and the display encoder.
package seg_pkg;

    // Scan FSM states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBlank = 2'd1,
        StDrive = 2'd2
    } scan_state_t;

    // All segments dark, active-high
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Segment bit positions within a digit byte
    localparam int unsigned SEG_A_BIT  = 0;
    localparam int unsigned SEG_B_BIT  = 1;
    localparam int unsigned SEG_C_BIT  = 2;
    localparam int unsigned SEG_D_BIT  = 3;
    localparam int unsigned SEG_E_BIT  = 4;
    localparam int unsigned SEG_F_BIT  = 5;
    localparam int unsigned SEG_G_BIT  = 6;
    localparam int unsigned SEG_DP_BIT = 7;

endpackage

// File: rtl/scan_slot_timer.sv
// Per-digit slot counter: a BLANK_CYCLES blanking gap followed by the drive window,
// PERIOD cycles in total. Strobes mark the last cycle of each phase.
module scan_slot_timer #(
    parameter int unsigned PERIOD       = 270,
    parameter int unsigned BLANK_CYCLES = 27
) (
    input  logic clkIn,
    input  logic resetIn,
    input  logic clear,
    input  logic advance,
    output logic last_blank,
    output logic last_drive
);

    localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CntW-1:0] LastCnt   = CntW'(PERIOD - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam bit HasBlank = (BLANK_CYCLES != 0);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise wrap at the end of the slot
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (advance) begin
            cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
        end
    end

    // Slot counter register
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_blank = HasBlank && (cnt_q == BlankLast);
    assign last_drive = (cnt_q == LastCnt);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment driver: frame-atomic data update, blanking gap between
// digits, 4-bit PWM brightness inside each digit's drive window.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY    = 27000000,
    parameter int unsigned SCAN_RATE_HZ     = 100000,
    parameter int unsigned BLANK_CYCLES     = 27,
    parameter int unsigned DIGITS           = 4,
    parameter bit          SEG_ACTIVE_LOW   = 1'b0,
    parameter bit          DIGIT_ACTIVE_LOW = 1'b0
) (
    input  logic                  clkIn,
    input  logic                  resetIn,
    input  logic [DIGITS*8-1:0]   segmentDataIn,
    input  logic                  dataValidIn,
    input  logic [3:0]            brightnessIn,
    input  logic                  enableIn,
    output logic [DIGITS-1:0]     digitEnableOut,
    output logic [7:0]            segmentEnableOut,
    output logic                  frameDoneOut
);

    localparam int unsigned PERIOD = CLK_FREQUENCY / SCAN_RATE_HZ;
    localparam int unsigned IdxW   = $clog2(DIGITS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);
    localparam bit HasBlank = (BLANK_CYCLES != 0);

    // Polarity masks, applied only at the output registers
    localparam logic [DIGITS-1:0] DigitMask = DIGIT_ACTIVE_LOW ? {DIGITS{1'b1}} : '0;
    localparam logic [7:0]        SegMask   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    if (PERIOD < 2 || BLANK_CYCLES >= PERIOD - 1) begin : g_bad_blank
        $error("seg_scan_driver: BLANK_CYCLES must be less than PERIOD-1");
    end
    if (DIGITS < 2) begin : g_bad_digits
        $error("seg_scan_driver: DIGITS must be at least 2");
    end

    scan_state_t state_q, state_d;
    logic [IdxW-1:0] index_q, index_d;
    logic [3:0] pwm_q, pwm_d;

    logic [DIGITS-1:0][7:0] seg_in;
    logic [DIGITS-1:0][7:0] shadow_q, shadow_d;
    logic [DIGITS-1:0][7:0] visible_q, visible_d;
    logic pending_q, pending_d;

    logic last_blank, last_drive;
    logic timer_clear, timer_advance;
    logic boundary, frame_start, drive_entry, lit;

    logic [DIGITS-1:0] digit_act, digit_q;
    logic [7:0] seg_act, seg_q;
    logic frame_done_d, frame_done_q;

    assign seg_in = segmentDataIn;

    // Counter restarts whenever the scan (re)starts from idle
    assign timer_clear   = !enableIn || (state_q == StIdle);
    assign timer_advance = enableIn && (state_q != StIdle);

    scan_slot_timer #(
        .PERIOD       (PERIOD),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clkIn      (clkIn),
        .resetIn    (resetIn),
        .clear      (timer_clear),
        .advance    (timer_advance),
        .last_blank (last_blank),
        .last_drive (last_drive)
    );

    // Wrap of the last digit is the frame boundary; leaving idle also starts a frame
    assign boundary    = enableIn && (state_q == StDrive) && last_drive && (index_q == LastIdx);
    assign frame_start = boundary || (enableIn && (state_q == StIdle));

    // FSM state, digit index and PWM phase registers
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state_q <= StIdle;
            index_q <= '0;
            pwm_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            pwm_q   <= pwm_d;
        end
    end

    // FSM next state and digit index
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        if (!enableIn) begin
            state_d = StIdle;
            index_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = HasBlank ? StBlank : StDrive;
                    index_d = '0;
                end
                StBlank: begin
                    if (last_blank) begin
                        state_d = StDrive;
                    end
                end
                StDrive: begin
                    if (last_drive) begin
                        state_d = HasBlank ? StBlank : StDrive;
                        index_d = (index_q == LastIdx) ? '0 : index_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    index_d = '0;
                end
            endcase
        end
    end

    // Output decode from the state being entered, so outputs line up with the state
    always_comb begin
        drive_entry = (state_d == StDrive) && ((state_q != StDrive) || last_drive);
        pwm_d = pwm_q;
        if (drive_entry) begin
            pwm_d = '0;
        end else if ((state_q == StDrive) && (state_d == StDrive)) begin
            pwm_d = pwm_q + 4'd1;
        end
        lit = (brightnessIn == 4'hF) || (pwm_d < brightnessIn);
        digit_act = '0;
        seg_act   = SEG_OFF;
        if (state_d == StDrive) begin
            digit_act[index_d] = 1'b1;
            if (lit) begin
                seg_act = visible_d[index_d];
            end
        end
        frame_done_d = boundary;
    end

    // Shadow capture and frame-start commit; a load on the commit edge goes straight through
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        visible_d = visible_q;
        if (dataValidIn) begin
            shadow_d  = seg_in;
            pending_d = 1'b1;
        end
        if (frame_start) begin
            if (dataValidIn) begin
                visible_d = seg_in;
            end else if (pending_q) begin
                visible_d = shadow_q;
            end
            pending_d = 1'b0;
        end
    end

    // Data registers
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            shadow_q  <= '0;
            visible_q <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            visible_q <= visible_d;
            pending_q <= pending_d;
        end
    end

    // Output registers with pin polarity applied
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            digit_q      <= DigitMask;
            seg_q        <= SEG_OFF ^ SegMask;
            frame_done_q <= 1'b0;
        end else begin
            digit_q      <= digit_act ^ DigitMask;
            seg_q        <= seg_act ^ SegMask;
            frame_done_q <= frame_done_d;
        end
    end

    assign digitEnableOut   = digit_q;
    assign segmentEnableOut = seg_q;
    assign frameDoneOut     = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: one active-high and one active-low instance share the
// same stimulus; expected per-cycle outputs are queued and compared as they appear.
module tb_seg_scan_driver;

    localparam int unsigned ClkFreq  = 1000;
    localparam int unsigned ScanRate = 100;
    localparam int unsigned Blank    = 2;
    localparam int unsigned Digits   = 4;

    typedef struct packed {
        logic [3:0] dig;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] seg_data;
    logic        data_valid;
    logic [3:0]  bright;
    logic        enable;

    logic [3:0] dig_a, dig_b;
    logic [7:0] seg_a, seg_b;
    logic       fd_a, fd_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    seg_scan_driver #(
        .CLK_FREQUENCY    (ClkFreq),
        .SCAN_RATE_HZ     (ScanRate),
        .BLANK_CYCLES     (Blank),
        .DIGITS           (Digits),
        .SEG_ACTIVE_LOW   (1'b0),
        .DIGIT_ACTIVE_LOW (1'b0)
    ) dut_hi (
        .clkIn            (clk),
        .resetIn          (rst_n),
        .segmentDataIn    (seg_data),
        .dataValidIn      (data_valid),
        .brightnessIn     (bright),
        .enableIn         (enable),
        .digitEnableOut   (dig_a),
        .segmentEnableOut (seg_a),
        .frameDoneOut     (fd_a)
    );

    seg_scan_driver #(
        .CLK_FREQUENCY    (ClkFreq),
        .SCAN_RATE_HZ     (ScanRate),
        .BLANK_CYCLES     (Blank),
        .DIGITS           (Digits),
        .SEG_ACTIVE_LOW   (1'b1),
        .DIGIT_ACTIVE_LOW (1'b1)
    ) dut_lo (
        .clkIn            (clk),
        .resetIn          (rst_n),
        .segmentDataIn    (seg_data),
        .dataValidIn      (data_valid),
        .brightnessIn     (bright),
        .enableIn         (enable),
        .digitEnableOut   (dig_b),
        .segmentEnableOut (seg_b),
        .frameDoneOut     (fd_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] dig, input logic [7:0] seg, input logic fd);
        exp_t e;
        e.dig = dig;
        e.seg = seg;
        e.fd  = fd;
        sb_q.push_back(e);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_exp(4'h0, 8'h00, 1'b0);
    endtask

    // Two blank cycles, then ndrive drive cycles with the PWM pattern for this brightness
    task automatic push_slot(input int d, input logic [7:0] b, input int br, input logic fd,
                             input int ndrive);
        logic [3:0] sel;
        sel = 4'(1 << d);
        push_exp(4'h0, 8'h00, fd);
        push_exp(4'h0, 8'h00, 1'b0);
        for (int k = 0; k < ndrive; k++) begin
            push_exp(sel, ((br == 15) || (k < br)) ? b : 8'h00, 1'b0);
        end
    endtask

    task automatic push_frame(input logic [31:0] data, input int br, input logic first);
        for (int d = 0; d < 4; d++) begin
            push_slot(d, data[8*d +: 8], br, (d == 0) && !first, 8);
        end
    endtask

    // Advance n cycles, comparing both instances against the head of the scoreboard
    task automatic drain(input int n);
        exp_t e;
        logic [3:0] dinv;
        logic [7:0] sinv;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check_eq("sb_underrun", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                dinv = ~e.dig;
                sinv = ~e.seg;
                check_eq("digit_hi", dig_a, e.dig);
                check_eq("seg_hi",   seg_a, e.seg);
                check_eq("fdone_hi", fd_a,  e.fd);
                check_eq("digit_lo", dig_b, dinv);
                check_eq("seg_lo",   seg_b, sinv);
                check_eq("fdone_lo", fd_b,  e.fd);
            end
            data_valid = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_digit_hi"}, dig_a, 32'h0);
        check_eq({tag, "_seg_hi"},   seg_a, 32'h00);
        check_eq({tag, "_fdone_hi"}, fd_a,  32'h0);
        check_eq({tag, "_digit_lo"}, dig_b, 32'hF);
        check_eq({tag, "_seg_lo"},   seg_b, 32'hFF);
        check_eq({tag, "_fdone_lo"}, fd_b,  32'h0);
    endtask

    initial begin
        rst_n      = 1'b1;
        seg_data   = '0;
        data_valid = 1'b0;
        bright     = 4'd0;
        enable     = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load while idle, then start scanning at full brightness
        seg_data   = 32'h3F065B4F;
        data_valid = 1'b1;
        bright     = 4'd15;
        push_idle(1);
        drain(1);
        enable = 1'b1;
        push_frame(32'h3F065B4F, 15, 1'b1);
        push_frame(32'h3F065B4F, 15, 1'b0);
        drain(80);

        // Two loads mid-frame: old data holds, last load shows next frame
        push_frame(32'h3F065B4F, 15, 1'b0);
        push_frame(32'hAABBCCDD, 15, 1'b0);
        drain(15);
        seg_data   = 32'h11223344;
        data_valid = 1'b1;
        drain(10);
        seg_data   = 32'hAABBCCDD;
        data_valid = 1'b1;
        drain(55);

        // PWM brightness
        bright = 4'd4;
        push_frame(32'hAABBCCDD, 4, 1'b0);
        drain(40);
        bright = 4'd0;
        push_frame(32'hAABBCCDD, 0, 1'b0);
        drain(40);

        // Disable in the middle of digit 2's drive window, load while disabled, re-enable
        bright = 4'd15;
        push_slot(0, 8'hDD, 15, 1'b1, 8);
        push_slot(1, 8'hCC, 15, 1'b0, 8);
        push_slot(2, 8'hBB, 15, 1'b0, 4);
        drain(26);
        enable     = 1'b0;
        seg_data   = 32'h11223344;
        data_valid = 1'b1;
        push_idle(3);
        drain(3);
        enable = 1'b1;
        push_frame(32'h11223344, 15, 1'b1);
        drain(40);

        // Asynchronous reset while driving digit 0
        push_slot(0, 8'h44, 15, 1'b1, 3);
        drain(5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        check_eq("sb_left", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
